vga_pix_strobe_gen: RTL



---
 rtl/vga_pix_strobe_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_pix_strobe_gen.sv
// -----------------------------------------------------------------------------
// vga_pix_strobe_gen
//
// Pixel-rate clock-enable generator for the VGA pipeline. A phase accumulator
// running on the 100 MHz system clock produces a single-cycle strobe at the
// fractional rate f_clk * step / 2^ACC_W. The step is chosen from a table of
// N_MODES entries through a level req/valid handshake; after a mode is
// accepted the strobe stays quiet for SETTLE_CYCLES before valid_o rises.
//
// Ports:
//   clk_100m_i    in   system clock, 100 MHz
//   arstn_i       in   asynchronous active-low reset
//   req_i         in   mode-change request (level, held until valid_o)
//   mode_i        in   requested mode index, sampled with req_i
//   strobe_o      out  one-cycle pixel enable
//   valid_o       out  strobe running at the currently selected mode
//   mode_o        out  currently active mode
//   err_o         out  one-cycle pulse when a request names a mode >= N_MODES
//   strobe_cnt_o  out  strobes since entering RUN (monitor build only, else 0)
//
// Build option:
//   VGA_PIX_STROBE_MON_EN  when defined, strobe_cnt_o counts strobes since the
//                          last RUN entry, saturating at 16'hFFFF. When not
//                          defined the counter is absent and strobe_cnt_o = 0.
// -----------------------------------------------------------------------------
module vga_pix_strobe_gen #(
  parameter int ACC_W         = 32,
  parameter int N_MODES       = 4,
  parameter int MODE_W        = (N_MODES > 1) ? $clog2(N_MODES) : 1,
  parameter int SETTLE_CYCLES = 16,
  parameter logic [N_MODES*ACC_W-1:0] MODE_STEPS =
    {32'd0, 32'd2791728742, 32'd1717986918, 32'd1081258017}
) (
  input  logic              clk_100m_i,
  input  logic              arstn_i,
  input  logic              req_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic              strobe_o,
  output logic              valid_o,
  output logic [MODE_W-1:0] mode_o,
  output logic              err_o,
  output logic [15:0]       strobe_cnt_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   step_q, step_d;
  logic               strobe_q, strobe_d;
  logic               arm_q, arm_d;
  logic               err_q, err_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]   settleCnt_q, settleCnt_d;

  logic               modeValid;
  logic               reqTake;
  logic [ACC_W-1:0]   stepSel;
  logic [ACC_W:0]     sum;

  // Table lookup by comparison so an out-of-range mode never indexes past
  // the packed step table.
  always_comb begin
    stepSel = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (32'(mode_i) == 32'(m)) begin
        stepSel = MODE_STEPS[m*ACC_W +: ACC_W];
      end
    end
  end

  assign modeValid = (32'(mode_i) < 32'(N_MODES));
  assign sum       = {1'b0, acc_q} + {1'b0, step_q};

  // A request is only looked at outside SETTLE, and only once per low-to-high
  // sequence of req_i thanks to the arm flag.
  assign reqTake = (state_q != SETTLE) && req_i && arm_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    step_d      = step_q;
    strobe_d    = 1'b0;
    arm_d       = arm_q;
    err_d       = 1'b0;
    mode_d      = mode_q;
    settleCnt_d = settleCnt_q;

    if (!req_i) begin
      arm_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        acc_d = '0;
      end
      SETTLE: begin
        acc_d = '0;
        if (settleCnt_q == '0) begin
          state_d = RUN;
        end else begin
          settleCnt_d = settleCnt_q - 1'b1;
        end
      end
      RUN: begin
        // Carry out of the accumulator is the pixel strobe.
        acc_d    = sum[ACC_W-1:0];
        strobe_d = sum[ACC_W];
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase

    // A rejected request leaves the running mode untouched.
    if (reqTake) begin
      arm_d = 1'b0;
      if (modeValid) begin
        state_d     = SETTLE;
        acc_d       = '0;
        strobe_d    = 1'b0;
        step_d      = stepSel;
        mode_d      = mode_i;
        settleCnt_d = SETTLE_LOAD;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      step_q      <= '0;
      strobe_q    <= 1'b0;
      arm_q       <= 1'b1;
      err_q       <= 1'b0;
      mode_q      <= '0;
      settleCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      strobe_q    <= strobe_d;
      arm_q       <= arm_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      settleCnt_q <= settleCnt_d;
    end
  end

  assign strobe_o = strobe_q;
  assign valid_o  = (state_q == RUN);
  assign mode_o   = mode_q;
  assign err_o    = err_q;

`ifdef VGA_PIX_STROBE_MON_EN
  logic [15:0] strobeCnt_q, strobeCnt_d;

  // Cleared on the SETTLE->RUN transition, then counts strobes and sticks
  // at all-ones.
  always_comb begin
    strobeCnt_d = strobeCnt_q;
    if ((state_q == SETTLE) && (state_d == RUN)) begin
      strobeCnt_d = '0;
    end else if (strobe_q && (strobeCnt_q != 16'hFFFF)) begin
      strobeCnt_d = strobeCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      strobeCnt_q <= '0;
    end else begin
      strobeCnt_q <= strobeCnt_d;
    end
  end

  assign strobe_cnt_o = strobeCnt_q;
`else
  assign strobe_cnt_o = 16'd0;
`endif

endmodule
